key_unlock_ctrl: RTL and testbench
==================================

// Module: key_unlock_ctrl
// PURPOSE
// - Sequences activation of the 7-key-bit logic-locked mixed-gate core: serially loads a candidate key, drives it to the core's key inputs, and runs a 16-vector self-test against a golden response.
// - Only after the self-test passes are functional inputs/outputs routed through the core. Failed attempts are counted, and a sticky lockout follows MAX_FAIL failures.
// - Sits between the chip-level key port / functional pins and the locked core instance.
// PARAMETERS
// - GOLDEN    48'h0  expected core_out for vectors 0..15; bits [3v+2:3v] = {O3,O2,O1} for vector v
// - DECOY_KEY 7'h00  key driven to the core whenever not UNLOCKED
// - MAX_FAIL  3      failed self-tests before LOCKOUT (1..7)
// PORTS
// - clk        in   1  rising-edge clock
// - rst        in   1  synchronous, active-high reset
// - key_sdi    in   1  serial key bit, LSB (keyinput0) first
// - key_sen    in   1  shift enable; samples key_sdi on each clk where high
// - key_commit in   1  single-cycle pulse; starts the self-test
// - func_in    in   4  functional {I4,I3,I2,I1}
// - func_out   out  3  functional {O3,O2,O1}; 0 unless UNLOCKED
// - core_in    out  4  to core I4..I1
// - core_key   out  7  to core keyinput6..0
// - core_out   in   3  from core {O3,O2,O1} (combinational path)
// - busy       out  1  self-test in progress
// - unlocked   out  1  high in UNLOCKED
// - fail_pulse out  1  one-cycle pulse on a failed self-test
// - err_pulse  out  1  one-cycle pulse on a rejected commit
// - lockout    out  1  sticky until rst
// - fail_cnt   out  3  saturating count of failed self-tests
// BEHAVIOUR
// - Reset: state=IDLE; key_reg=0; bit_cnt=0; fail_cnt=0; all status outputs 0; func_out=0; core_key=DECOY_KEY; core_in=0.
// - Shift: in IDLE, key_sen=1 gives key_reg <= {key_sdi,key_reg[6:1]} and bit_cnt <= min(bit_cnt+1,7). key_sen is ignored in TEST and LOCKOUT.
// - States: IDLE, TEST, UNLOCKED, LOCKOUT.
// - IDLE: commit with bit_cnt==7 -> TEST, vec=0. Commit with bit_cnt<7 -> err_pulse; stay in IDLE; fail_cnt unchanged.
// - TEST: 16 cycles; core_key=key_reg; core_in=vec. Compare core_out with GOLDEN[3vec+:3] in the same cycle and AND into a match flag; vec++. busy=1.
// - After vec 15: match -> UNLOCKED. Mismatch -> fail_pulse, fail_cnt++, bit_cnt=0; go to LOCKOUT if fail_cnt reaches MAX_FAIL, else IDLE.
// - Latency: commit sampled at cycle T; vectors applied T+1..T+16; unlocked or fail_pulse asserts at T+17.
// - UNLOCKED: core_key=key_reg; core_in=func_in; func_out=core_out (combinational passthrough). key_sen is allowed and arms a new key. A commit re-enters TEST, with unlocked=0 and func_out=0 during the test.
// - LOCKOUT: core_key=DECOY_KEY; func_out=0; all key/commit inputs ignored; only rst exits.
// - Simultaneous key_sen and key_commit in IDLE: commit is evaluated on the pre-shift bit_cnt; the shift is discarded.
// - Commit during TEST is ignored (no error).
// - rst mid-TEST aborts immediately to reset values; fail_cnt is cleared.
// - fail_cnt saturates at 7.
// CONFIGURATION
// - KEYCTL_ZEROIZE_EN defined: every failed self-test and LOCKOUT entry clears key_reg to 0 in the same cycle as fail_pulse.
// - KEYCTL_ZEROIZE_EN undefined: key_reg keeps the failed key (bit_cnt is still cleared). The key is visible only inside the block; core_key still shows DECOY_KEY.
// TESTING
// - Correct key: shift 7'b0110101 (LSB first), commit, with GOLDEN = core responses under that key -> busy for 16 cycles, unlocked=1 at T+17; func_in=4'b1111 -> func_out = core value.
// - Wrong key: 7'b0000000 committed 3x with MAX_FAIL=3 -> three fail_pulses, fail_cnt=3, lockout=1. Then the correct key plus commit -> ignored; core_key=DECOY_KEY.
// - Short key: 4 shifts then commit -> err_pulse=1 for 1 cycle, state IDLE, fail_cnt=0.
// - rst at T+8 of a self-test -> next cycle busy=0, fail_cnt=0, core_key=DECOY_KEY, func_out=0.
// - Re-key from UNLOCKED: shift a wrong key and commit -> func_out=0 during TEST, then fail_pulse, unlocked=0, fail_cnt=1.
// - Zeroize: build with and without KEYCTL_ZEROIZE_EN, fail once, probe key_reg -> 0 with the macro, last key without.

Source files
------------

// File: rtl/key_unlock_ctrl.sv
// Key unlock controller: serial key load, 16-vector self-test of the locked core, then gated passthrough.
// Optional KEYCTL_ZEROIZE_EN clears the held key on every failed self-test.
module key_unlock_ctrl #(
  parameter logic [47:0] GOLDEN    = 48'h0,
  parameter logic [6:0]  DECOY_KEY = 7'h00,
  parameter int          MAX_FAIL  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_sdi,
  input  logic       key_sen,
  input  logic       key_commit,
  input  logic [3:0] func_in,
  output logic [2:0] func_out,
  output logic [3:0] core_in,
  output logic [6:0] core_key,
  input  logic [2:0] core_out,
  output logic       busy,
  output logic       unlocked,
  output logic       fail_pulse,
  output logic       err_pulse,
  output logic       lockout,
  output logic [2:0] fail_cnt
);

  typedef enum logic [1:0] {IDLE, TEST, UNLOCKED, LOCKOUT} state_t;

  localparam logic [2:0] MAX_F = 3'(MAX_FAIL);

  state_t     state;
  logic [6:0] key_reg;
  logic [2:0] bit_cnt;
  logic [3:0] vec;
  logic       match;

  logic [5:0] gidx;
  logic       vec_ok;
  logic [2:0] fail_nxt;

  assign gidx     = 6'(vec) * 6'd3;
  assign vec_ok   = (core_out == GOLDEN[gidx +: 3]);
  assign fail_nxt = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;

  // The real key only reaches the core while testing or unlocked.
  assign core_key = (state == TEST || state == UNLOCKED) ? key_reg : DECOY_KEY;
  assign core_in  = (state == TEST) ? vec : (state == UNLOCKED) ? func_in : 4'h0;
  assign func_out = unlocked ? core_out : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_reg    <= 7'h00;
      bit_cnt    <= 3'd0;
      vec        <= 4'd0;
      match      <= 1'b0;
      busy       <= 1'b0;
      unlocked   <= 1'b0;
      fail_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      lockout    <= 1'b0;
      fail_cnt   <= 3'd0;
    end else begin
      fail_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        IDLE, UNLOCKED: begin
          // A commit wins over a simultaneous shift; the shift is dropped.
          if (key_commit) begin
            if (state == UNLOCKED || bit_cnt == 3'd7) begin
              state    <= TEST;
              vec      <= 4'd0;
              match    <= 1'b1;
              busy     <= 1'b1;
              unlocked <= 1'b0;
            end else begin
              err_pulse <= 1'b1;
            end
          end else if (key_sen) begin
            key_reg <= {key_sdi, key_reg[6:1]};
            if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
          end
        end
        TEST: begin
          match <= match & vec_ok;
          vec   <= vec + 4'd1;
          if (vec == 4'd15) begin
            busy <= 1'b0;
            if (match && vec_ok) begin
              state    <= UNLOCKED;
              unlocked <= 1'b1;
            end else begin
              fail_pulse <= 1'b1;
              fail_cnt   <= fail_nxt;
              bit_cnt    <= 3'd0;
`ifdef KEYCTL_ZEROIZE_EN
              key_reg    <= 7'h00;
`endif
              if (fail_nxt >= MAX_F) begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: ;  // LOCKOUT: only rst leaves
      endcase
    end
  end

endmodule

// File: tb/tb_key_unlock_ctrl.sv
// Randomized bench for key_unlock_ctrl with a fake locked core and a behavioural reference model.
module tb_key_unlock_ctrl;

  localparam logic [6:0] KEY_OK    = 7'b0110101;
  localparam logic [6:0] KEY_BAD   = 7'b1011010;
  localparam logic [6:0] DECOY     = 7'h00;
  localparam int         MAX_FAIL  = 3;

  function automatic logic [2:0] good(input logic [3:0] i);
    return {i[3] ^ i[0], i[2] & i[1], i[1] | i[3]};
  endfunction

  // Any wrong key corrupts every response (low bit always flips).
  function automatic logic [2:0] core_fn(input logic [3:0] i, input logic [6:0] k);
    logic [6:0] d;
    d = k ^ KEY_OK;
    if (d == 7'h00) return good(i);
    return good(i) ^ {d[1:0] ^ i[1:0], 1'b1};
  endfunction

  function automatic logic [47:0] gen_golden();
    logic [47:0] g;
    g = '0;
    for (int v = 0; v < 16; v++) g[3*v +: 3] = good(4'(v));
    return g;
  endfunction

  localparam logic [47:0] GOLD = gen_golden();

`ifdef KEYCTL_ZEROIZE_EN
  localparam logic [6:0] EXP_FAILED_KEY = 7'h00;
`else
  localparam logic [6:0] EXP_FAILED_KEY = KEY_BAD;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_sdi = 1'b0, key_sen = 1'b0, key_commit = 1'b0;
  logic [3:0] func_in = 4'h0;
  logic [2:0] func_out, core_out, fail_cnt;
  logic [3:0] core_in;
  logic [6:0] core_key;
  logic       busy, unlocked, fail_pulse, err_pulse, lockout;

  assign core_out = core_fn(core_in, core_key);

  key_unlock_ctrl #(.GOLDEN(GOLD), .DECOY_KEY(DECOY), .MAX_FAIL(MAX_FAIL)) dut (
    .clk(clk), .rst(rst), .key_sdi(key_sdi), .key_sen(key_sen), .key_commit(key_commit),
    .func_in(func_in), .func_out(func_out), .core_in(core_in), .core_key(core_key),
    .core_out(core_out), .busy(busy), .unlocked(unlocked), .fail_pulse(fail_pulse),
    .err_pulse(err_pulse), .lockout(lockout), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a test passes exactly when the held key is the correct one.
  int         m_tcnt;
  bit         m_unl, m_lock, m_failp, m_errp;
  int         m_cnt, m_fail;
  logic [6:0] m_key;

  task automatic model_step();
    m_errp  = 1'b0;
    m_failp = 1'b0;
    if (rst) begin
      m_tcnt = 0; m_unl = 0; m_lock = 0; m_cnt = 0; m_fail = 0; m_key = 7'h00;
    end else if (m_tcnt > 0) begin
      m_tcnt--;
      if (m_tcnt == 0) begin
        if (m_key == KEY_OK) m_unl = 1'b1;
        else begin
          m_failp = 1'b1;
          m_fail  = (m_fail < 7) ? m_fail + 1 : 7;
          m_cnt   = 0;
`ifdef KEYCTL_ZEROIZE_EN
          m_key   = 7'h00;
`endif
          if (m_fail >= MAX_FAIL) m_lock = 1'b1;
        end
      end
    end else if (!m_lock) begin
      if (key_commit) begin
        if (m_unl || m_cnt == 7) begin m_tcnt = 16; m_unl = 1'b0; end
        else m_errp = 1'b1;
      end else if (key_sen) begin
        m_key = {key_sdi, m_key[6:1]};
        m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("busy",       busy,       int'(m_tcnt > 0));
      check("unlocked",   unlocked,   m_unl);
      check("lockout",    lockout,    m_lock);
      check("fail_pulse", fail_pulse, m_failp);
      check("err_pulse",  err_pulse,  m_errp);
      check("fail_cnt",   fail_cnt,   m_fail);
      check("key_reg",    dut.key_reg, m_key);
      check("core_key",   core_key,   (m_tcnt > 0 || m_unl) ? m_key : DECOY);
      check("core_in",    core_in,    (m_tcnt > 0) ? 16 - m_tcnt : (m_unl ? func_in : 0));
      check("func_out",   func_out,   m_unl ? core_fn(func_in, m_key) : 3'b000);
    end
  end

  // Inputs are applied 2 time units after an edge and held across the next edge.
  task automatic step(input bit r, input bit s, input bit d, input bit c, input logic [3:0] fi);
    rst = r; key_sen = s; key_sdi = d; key_commit = c; func_in = fi;
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 4'($urandom));
  endtask

  task automatic load_key(input logic [6:0] k);
    for (int i = 0; i < 7; i++) step(0, 1, k[i], 0, 4'($urandom));
  endtask

  // Runs a self-test that was just committed; returns its busy length.
  task automatic run_test(output int n);
    n = 1;
    while (busy && n < 40) begin
      check("func_out_in_test", func_out, 0);
      idle();
      if (busy) n++;
    end
  endtask

  initial begin
    int n;
    logic [6:0] k;
    int nb, gap;

    step(1, 0, 0, 0, 4'h0);
    step(1, 0, 0, 0, 4'h0);
    check_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_core_key", core_key, DECOY);
    check("rst_func_out", func_out, 0);

    // Short key: error pulse for a single cycle, nothing else moves.
    for (int i = 0; i < 4; i++) step(0, 1, 1'b1, 0, 4'h0);
    step(0, 0, 0, 1, 4'h0);
    check("short_err", err_pulse, 1);
    check("short_busy", busy, 0);
    idle();
    check("short_err_clear", err_pulse, 0);
    check("short_fail_cnt", fail_cnt, 0);

    // Correct key: 16 busy cycles then unlocked passthrough.
    load_key(KEY_OK);
    step(0, 0, 0, 1, 4'h0);
    check("ok_busy_start", busy, 1);
    run_test(n);
    check("ok_busy_len", n, 16);
    check("ok_unlocked", unlocked, 1);
    step(0, 0, 0, 0, 4'b1111);
    check("ok_core_in", core_in, 4'b1111);
    check("ok_func_out", func_out, 3'b011);

    // Re-key from unlocked with a wrong key.
    load_key(KEY_BAD);
    step(0, 0, 0, 1, 4'b1111);
    check("rekey_unl_drop", unlocked, 0);
    run_test(n);
    check("rekey_busy_len", n, 16);
    check("rekey_fail_pulse", fail_pulse, 1);
    check("rekey_fail_cnt", fail_cnt, 1);
    check("zeroize_key", dut.key_reg, EXP_FAILED_KEY);

    // Two more failures reach lockout.
    for (int a = 0; a < 2; a++) begin
      load_key(7'h00);
      step(0, 0, 0, 1, 4'h0);
      run_test(n);
    end
    check("lock_fail_cnt", fail_cnt, 3);
    check("lock_lockout", lockout, 1);
    load_key(KEY_OK);
    step(0, 0, 0, 1, 4'h0);
    idle();
    check("lock_ignored_busy", busy, 0);
    check("lock_core_key", core_key, DECOY);

    // Reset in the middle of a self-test.
    step(1, 0, 0, 0, 4'h0);
    load_key(KEY_BAD);
    step(0, 0, 0, 1, 4'h0);
    run_test(n);
    load_key(KEY_OK);
    step(0, 0, 0, 1, 4'h0);
    for (int i = 0; i < 7; i++) idle();
    step(1, 0, 0, 0, 4'hf);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fail_cnt", fail_cnt, 0);
    check("mid_rst_core_key", core_key, DECOY);
    check("mid_rst_func_out", func_out, 0);

    // Random episodes.
    for (int ep = 0; ep < 80; ep++) begin
      if ($urandom_range(0, 5) == 0) step(1, 0, 0, 0, 4'($urandom));
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : 7;
      k  = ($urandom_range(0, 2) == 0) ? KEY_OK : 7'($urandom);
      for (int i = 0; i < nb; i++) step(0, 1, k[i % 7], 0, 4'($urandom));
      step(0, 1'($urandom), 1'($urandom), 1, 4'($urandom));
      gap = $urandom_range(0, 24);
      for (int i = 0; i < gap; i++)
        step($urandom_range(0, 60) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
             $urandom_range(0, 9) == 0, 4'($urandom));
    end

    idle();
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
